// File: rtl/plot_receiver_pkg.sv
// Shared definitions for the pixel plot receiver: screen geometry, FIFO sizing,
// FSM state encoding and the framebuffer address helper.
package plot_receiver_pkg;

  // Visible resolution of the framebuffer.
  localparam logic [7:0] H_RES = 8'd160;
  localparam logic [6:0] V_RES = 7'd120;

  // Write buffer geometry.
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int ADDR_W     = 15;
  localparam int COLOUR_W   = 3;
  localparam int FIFO_W     = ADDR_W + COLOUR_W;

  // Occupancy value that marks the buffer as full.
  localparam logic [PTR_W:0] COUNT_FULL = 3'd4;

  // Saturation limits of the frame statistics counters.
  localparam logic [15:0] PIX_MAX  = 16'hFFFF;
  localparam logic [7:0]  DROP_MAX = 8'hFF;

  // Receiver control states.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH  = 2'b01,
    ST_REPORT = 2'b10
  } state_e;

  // One buffered framebuffer write.
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } fifo_entry_t;

  // Linear framebuffer address y*160 + x, built from shifts so no multiplier
  // is needed: 160 = 128 + 32.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x,
                                                 input logic [6:0] y);
    logic [ADDR_W-1:0] y_w;
    logic [ADDR_W-1:0] x_w;
    y_w = {8'd0, y};
    x_w = {7'd0, x};
    return (y_w << 7) + (y_w << 5) + x_w;
  endfunction

  // True when the coordinate lies on the visible screen.
  function automatic logic in_bounds(input logic [7:0] x,
                                     input logic [6:0] y);
    return (x < H_RES) && (y < V_RES);
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO holding pending framebuffer writes. Push and pop may
// happen on the same edge; a push while full or a pop while empty is ignored.
module plot_fifo
  import plot_receiver_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [FIFO_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [FIFO_W-1:0] head
);

  logic [FIFO_W-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push_s;
  logic              do_pop_s;

  // Status flags and head-of-queue view, all decoded from registered state.
  always_comb begin
    full  = (count_q == COUNT_FULL);
    empty = (count_q == 3'd0);
    head  = mem_q[rd_ptr_q];
  end

  // Qualify requests so overflow/underflow can never corrupt the pointers.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
  end

  // Storage and pointer next-state.
  always_comb begin
    mem_d = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Occupancy tracking; simultaneous push and pop leave it unchanged.
  always_comb begin
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {FIFO_W{1'b0}};
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/plot_receiver.sv
// Pixel plot receiver: accepts pixels from a drawing unit, discards
// off-screen ones, buffers the rest and streams them to the framebuffer.
// At the end of each frame it drains the buffer and reports per-frame
// written/dropped pixel counts.
module plot_receiver
  import plot_receiver_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_plot,
  input  logic [7:0]          in_x,
  input  logic [6:0]          in_y,
  input  logic [2:0]          in_colour,
  output logic                in_ready,
  input  logic                frame_done,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  input  logic                mem_ready,
  output logic [15:0]         pix_count,
  output logic [7:0]          drop_count,
  output logic                count_valid
);

  state_e             state_q, state_d;
  logic [15:0]        pix_cnt_q, pix_cnt_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [15:0]        pix_count_q, pix_count_d;
  logic [7:0]         drop_count_q, drop_count_d;
  logic               count_valid_q, count_valid_d;

  logic               in_ready_s;
  logic               accept_s;
  logic               in_range_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [FIFO_W-1:0]  fifo_din_s;
  logic [FIFO_W-1:0]  fifo_head_s;
  fifo_entry_t        entry_s;

  plot_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push_s),
    .pop     (fifo_pop_s),
    .din     (fifo_din_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .head    (fifo_head_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: end of frame starts a drain, an empty buffer ends it,
  // and the report lasts one cycle. frame_done only matters while running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (frame_done) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty_s) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_REPORT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM outputs: pixels are taken only while running with buffer space.
  // Full is the registered flag, so a same-cycle pop cannot raise in_ready.
  always_comb begin
    case (state_q)
      ST_RUN:    in_ready_s = !fifo_full_s;
      ST_FLUSH:  in_ready_s = 1'b0;
      ST_REPORT: in_ready_s = 1'b0;
      default:   in_ready_s = 1'b0;
    endcase
  end

  // Handshakes and buffer traffic for the current cycle.
  always_comb begin
    accept_s       = in_plot && in_ready_s;
    in_range_s     = in_bounds(in_x, in_y);
    fifo_push_s    = accept_s && in_range_s;
    fifo_pop_s     = !fifo_empty_s && mem_ready;
    entry_s.addr   = pix_addr(in_x, in_y);
    entry_s.colour = in_colour;
    fifo_din_s     = entry_s;
  end

  // Frame statistics: count pops and off-screen accepts, saturating; the
  // report cycle publishes the totals and restarts counting for the next frame.
  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    pix_count_d   = pix_count_q;
    drop_count_d  = drop_count_q;
    count_valid_d = 1'b0;
    if (state_q == ST_REPORT) begin
      pix_count_d   = pix_cnt_q;
      drop_count_d  = drop_cnt_q;
      count_valid_d = 1'b1;
      pix_cnt_d     = 16'd0;
      drop_cnt_d    = 8'd0;
    end else begin
      if (fifo_pop_s && (pix_cnt_q != PIX_MAX)) begin
        pix_cnt_d = pix_cnt_q + 16'd1;
      end else begin
        pix_cnt_d = pix_cnt_q;
      end
      if (accept_s && !in_range_s && (drop_cnt_q != DROP_MAX)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Statistics and report registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_cnt_q     <= 16'd0;
      drop_cnt_q    <= 8'd0;
      pix_count_q   <= 16'd0;
      drop_count_q  <= 8'd0;
      count_valid_q <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      pix_count_q   <= pix_count_d;
      drop_count_q  <= drop_count_d;
      count_valid_q <= count_valid_d;
    end
  end

  // Output mapping; the write port is the buffer head, held until popped.
  always_comb begin
    in_ready    = in_ready_s;
    mem_we      = !fifo_empty_s;
    mem_addr    = fifo_head_s[FIFO_W-1:COLOUR_W];
    mem_data    = fifo_head_s[COLOUR_W-1:0];
    pix_count   = pix_count_q;
    drop_count  = drop_count_q;
    count_valid = count_valid_q;
  end

endmodule

// File: tb/tb_plot_receiver.sv
// Self-checking bench for plot_receiver: directed scenarios followed by a
// random phase, all checked each cycle against a queue-based frame model.
module tb_plot_receiver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_plot;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_ready;
  logic        frame_done;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_ready;
  logic [15:0] pix_count;
  logic [7:0]  drop_count;
  logic        count_valid;

  always #5 clk = ~clk;

  plot_receiver dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_plot     (in_plot),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_colour   (in_colour),
    .in_ready    (in_ready),
    .frame_done  (frame_done),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .pix_count   (pix_count),
    .drop_count  (drop_count),
    .count_valid (count_valid)
  );

  // Reference model: pending writes in accept order, frame phase, counters.
  int q_addr[$];
  int q_col[$];
  int m_mode;      // 0 = running, 1 = draining, 2 = reporting
  int m_pix;
  int m_drop;
  int m_rep_pix;
  int m_rep_drop;
  bit m_cv;

  int n_total = 0;
  int n_bad   = 0;
  int cv_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit plot, input int x, input int y, input int col,
                        input bit fd, input bit mr, input bit rn);
    in_plot    = plot;
    in_x       = 8'(x);
    in_y       = 7'(y);
    in_colour  = 3'(col);
    frame_done = fd;
    mem_ready  = mr;
    reset_n    = rn;
  endtask

  task automatic check_outputs();
    check("in_ready", in_ready, (m_mode == 0) && (q_addr.size() < 4));
    check("mem_we", mem_we, q_addr.size() != 0);
    if (q_addr.size() != 0) begin
      check("mem_addr", mem_addr, q_addr[0]);
      check("mem_data", mem_data, q_col[0]);
    end
    check("count_valid", count_valid, m_cv);
    check("pix_count", pix_count, m_rep_pix);
    check("drop_count", drop_count, m_drop_rep());
    if (count_valid === 1'b1) cv_seen++;
  endtask

  function automatic int m_drop_rep();
    return m_rep_drop;
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge, then check.
  task automatic step();
    bit ready;
    bit popped;
    bit accept;
    @(posedge clk);
    if (!reset_n) begin
      q_addr.delete();
      q_col.delete();
      m_mode = 0; m_pix = 0; m_drop = 0;
      m_rep_pix = 0; m_rep_drop = 0; m_cv = 0;
    end else begin
      ready  = (m_mode == 0) && (q_addr.size() < 4);
      popped = (q_addr.size() > 0) && mem_ready;
      accept = in_plot && ready;
      m_cv   = 0;
      case (m_mode)
        0: if (frame_done) m_mode = 1;
        1: if (q_addr.size() == 0) m_mode = 2;
        default: begin
          m_rep_pix  = m_pix;
          m_rep_drop = m_drop;
          m_cv       = 1;
          m_pix      = 0;
          m_drop     = 0;
          m_mode     = 0;
        end
      endcase
      if (popped) begin
        void'(q_addr.pop_front());
        void'(q_col.pop_front());
        if (m_pix < 65535) m_pix++;
      end
      if (accept) begin
        if (in_x < 160 && in_y < 120) begin
          q_addr.push_back(int'(in_y) * 160 + int'(in_x));
          q_col.push_back(int'(in_colour));
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  // Idle (mem_ready high) until a report pulse shows up, bounded.
  task automatic wait_report(input int max_cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      step();
      if (count_valid === 1'b1) seen = 1;
    end
    check("report_seen", seen, 1);
  endtask

  initial begin
    int cv_before;

    // Reset
    set_in(0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    check("rst_mem_we", mem_we, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_drop_count", drop_count, 0);
    set_in(0, 0, 0, 0, 0, 1, 1);
    step();
    check("rst_in_ready", in_ready, 1);

    // Single pixel, next-cycle write
    set_in(1, 79, 63, 4, 0, 1, 1);
    step();
    check("single_we", mem_we, 1);
    check("single_addr", mem_addr, 10159);
    check("single_data", mem_data, 4);
    set_in(0, 0, 0, 0, 0, 1, 1);
    step();
    check("single_we_off", mem_we, 0);

    // Backpressure: five offered, four taken
    for (int i = 0; i < 5; i++) begin
      set_in(1, 10 + i, 20 + i, i, 0, 0, 1);
      step();
    end
    check("bp_in_ready_full", in_ready, 0);
    check("bp_head_addr", mem_addr, 20 * 160 + 10);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 1);
      step();
    end
    check("bp_drained_we", mem_we, 0);
    check("bp_in_ready_back", in_ready, 1);

    // Range boundaries
    set_in(1, 160, 0, 1, 0, 1, 1);   step();
    set_in(1, 0, 120, 2, 0, 1, 1);   step();
    set_in(1, 159, 119, 5, 0, 1, 1); step();
    check("edge_addr", mem_addr, 19199);
    check("edge_data", mem_data, 5);
    set_in(0, 0, 0, 0, 1, 1, 1);
    step();
    set_in(0, 0, 0, 0, 0, 1, 1);
    wait_report(20);
    check("edge_pix_count", pix_count, 6);
    check("edge_drop_count", drop_count, 2);

    // Ten pixels, drain under backpressure
    cv_before = cv_seen;
    for (int i = 0; i < 10; i++) begin
      set_in(1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7),
             0, (i < 8), 1);
      step();
    end
    set_in(0, 0, 0, 0, 1, 0, 1);
    step();
    check("flush_in_ready_0", in_ready, 0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    step();
    check("flush_in_ready_1", in_ready, 0);
    step();
    check("flush_in_ready_2", in_ready, 0);
    set_in(1, 5, 5, 1, 0, 1, 1);
    wait_report(20);
    check("flush_pix_count", pix_count, 10);
    check("flush_drop_count", drop_count, 0);
    set_in(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step();
    check("flush_one_report", cv_seen - cv_before, 1);

    // frame_done with a pixel on the same edge, second frame_done ignored
    cv_before = cv_seen;
    set_in(1, 33, 44, 6, 1, 1, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1);
    step();
    set_in(0, 0, 0, 0, 1, 0, 1);
    step();
    set_in(0, 0, 0, 0, 0, 1, 1);
    wait_report(20);
    check("same_edge_pix_count", pix_count, 1);
    for (int i = 0; i < 6; i++) step();
    check("same_edge_one_report", cv_seen - cv_before, 1);

    // Reset with pixels buffered
    cv_before = cv_seen;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 100 + i, 7, 3, 0, 0, 1);
      step();
    end
    check("pre_rst_we", mem_we, 1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_pix_count", pix_count, 0);
    set_in(0, 0, 0, 0, 0, 1, 1);
    step();
    check("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) step();
    check("mid_rst_no_report", cv_seen - cv_before, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 175), $urandom_range(0, 127),
             $urandom_range(0, 7), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 399) != 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/plot_receiver.md
PLOT_RECEIVER -- requirements
Module: plot_receiver

Interface
REQ-001 clk  in  1  system clock, all logic on rising edge.
REQ-002 reset_n  in  1  reset, synchronous, active-low.
REQ-003 in_plot  in  1  pixel-valid strobe from a drawing unit.
REQ-004 in_x  in  8  pixel column; legal range 0..159.
REQ-005 in_y  in  7  pixel row; legal range 0..119.
REQ-006 in_colour  in  3  pixel colour {R,G,B}.
REQ-007 in_ready  out  1  receiver can take a pixel this cycle.
REQ-008 frame_done  in  1  one-cycle pulse; drawing unit finished current frame.
REQ-009 mem_we  out  1  framebuffer write request (valid).
REQ-010 mem_addr  out  15  framebuffer address = y*160 + x.
REQ-011 mem_data  out  3  colour to write.
REQ-012 mem_ready  in  1  framebuffer accepts the write this cycle.
REQ-013 pix_count  out  16  pixels written during last reported frame.
REQ-014 drop_count  out  8  out-of-range pixels discarded during last reported frame.
REQ-015 count_valid  out  1  one-cycle pulse; pix_count/drop_count just updated.

Function
REQ-016 Accept: pixel taken on a clock edge where in_plot=1 and in_ready=1; otherwise in_x/in_y/in_colour ignored.
REQ-017 Range check at accept: in_x>159 or in_y>119 -> pixel discarded (not stored), drop counter +1, saturating at 255.
REQ-018 In-range accepted pixel pushed into a 4-entry FIFO as {address, colour}; address = (y<<7)+(y<<5)+x, 15-bit, max 19199.
REQ-019 in_ready = 1 only in state RUN with FIFO not full; a pop in the same cycle does not raise in_ready while full.
REQ-020 mem_we = 1 whenever FIFO non-empty; mem_addr/mem_data show FIFO head, held stable until popped.
REQ-021 Pop on edge where mem_we=1 and mem_ready=1; pixel counter +1, saturating at 65535.
REQ-022 Latency: pixel accepted at edge N into empty FIFO drives mem_we/mem_addr/mem_data in the cycle after edge N.
REQ-023 Write order on mem_* equals accept order; no reordering, no duplication, no loss of in-range pixels.
REQ-024 FSM states RUN, FLUSH, REPORT.
REQ-025 RUN -> FLUSH on frame_done=1; a pixel accepted on that same edge counts in the current frame.
REQ-026 FLUSH: in_ready=0; draining continues; FLUSH -> REPORT on the edge where FIFO is empty (including after final pop).
REQ-027 REPORT lasts exactly one cycle: pix_count/drop_count loaded from internal counters, count_valid=1, internal counters cleared; -> RUN.
REQ-028 frame_done ignored in FLUSH and REPORT.
REQ-029 pix_count/drop_count hold their values between REPORT cycles.

Reset
REQ-030 reset_n=0 at an edge: state RUN, FIFO emptied, internal counters 0, pix_count=0, drop_count=0, count_valid=0.
REQ-031 During and after reset mem_we=0 until a new pixel is accepted; in_ready=1 first cycle after reset released.
REQ-032 Reset mid-frame or mid-FLUSH discards buffered pixels without writing them and without a report.

Structure
REQ-033 Shared package holds H_RES=160, V_RES=120, FIFO_DEPTH=4, ADDR_W=15, and the RUN/FLUSH/REPORT state encoding.
REQ-034 One sub-module plot_fifo: 4-entry, 18-bit-wide synchronous FIFO with push, pop, full, empty, head outputs.

Verification
REQ-035 Single pixel x=79,y=63,colour=3'b100, mem_ready=1 -> mem_we one cycle, mem_addr=10159, mem_data=3'b100.
REQ-036 mem_ready=0, push 5 pixels back-to-back -> 4 accepted, in_ready=0 on 5th; release mem_ready -> 4 writes in order, then in_ready=1.
REQ-037 Pixels (160,0) and (0,120) plus (159,119) -> only addr 19199 written; drop counter 2.
REQ-038 10 in-range pixels, frame_done with mem_ready=0 for 3 cycles -> in_ready=0 in FLUSH, count_valid pulses once after last write, pix_count=10, drop_count=0.
REQ-039 frame_done on same edge as accepted pixel -> that pixel included in reported pix_count; second frame_done during FLUSH -> no extra report.
REQ-040 reset_n=0 with 3 pixels buffered -> next cycle mem_we=0, pix_count=0, no count_valid pulse.
